serial_demux_router: RTL and testbench

- Sequential front-end that feeds the 1-to-4 demultiplexer (demux1to4).
- Receives a framed serial bit stream, decodes a 2-bit destination address, then streams the payload bits onto the demux's din with sel held at the decoded channel.
- Keeps a per-channel count of good frames and flags malformed frames.
- Connects directly to demux1to4: sel -> sel, din -> din.

---
 rtl/serial_demux_router.sv | 117 +++++++++++
 tb/tb_serial_demux_router.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_demux_router.sv
// Serial frame decoder feeding demux1to4: start, 2-bit addr, DATA_BITS payload, stop(0).
// Latency: 1 cycle from an accepted bit to the registered sel/din/data_valid/pulses.
// Backpressure: rx_valid=0 stalls all state; data and pulse outputs drop to 0 that cycle.
module serial_demux_router #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_bit,
    input  logic                 rx_valid,
    output logic [1:0]           sel,
    output logic                 din,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [4*CNT_W-1:0]   ch_count
);

    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, STOP} state_t;

    state_t          state, state_nxt;
    logic [BC_W-1:0] bit_cnt, bit_cnt_nxt;
    logic            addr_hi, addr_hi_nxt;
    logic            addr_half, addr_half_nxt;
    logic [1:0]      sel_nxt;
    logic            din_nxt, dv_nxt, done_nxt, err_nxt;
    logic [CNT_W-1:0] cnt [4];

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        addr_hi_nxt   = addr_hi;
        addr_half_nxt = addr_half;
        sel_nxt       = sel;
        din_nxt       = 1'b0;
        dv_nxt        = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_bit) begin
                        state_nxt     = ADDR;
                        addr_half_nxt = 1'b0;
                    end
                end
                ADDR: begin
                    if (!addr_half) begin
                        addr_hi_nxt   = rx_bit;
                        addr_half_nxt = 1'b1;
                    end else begin
                        sel_nxt       = {addr_hi, rx_bit};
                        addr_half_nxt = 1'b0;
                        bit_cnt_nxt   = '0;
                        state_nxt     = DATA;
                    end
                end
                DATA: begin
                    din_nxt = rx_bit;
                    dv_nxt  = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // A high stop bit is an error, never a new start bit.
                    done_nxt  = ~rx_bit;
                    err_nxt   = rx_bit;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            addr_hi    <= 1'b0;
            addr_half  <= 1'b0;
            sel        <= 2'd0;
            din        <= 1'b0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            addr_hi    <= addr_hi_nxt;
            addr_half  <= addr_half_nxt;
            sel        <= sel_nxt;
            din        <= din_nxt;
            data_valid <= dv_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            // sel still holds this frame's channel while in STOP.
            if (done_nxt) cnt[sel] <= cnt[sel] + 1'b1;
        end
    end

    assign busy = (state != IDLE);

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign ch_count[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule

// File: tb/tb_serial_demux_router.sv
// Bench: two instances (DATA_BITS=8/CNT_W=8 and DATA_BITS=1/CNT_W=4) checked every cycle against a frame-position model.
module tb_serial_demux_router;

    logic clk = 1'b0;
    logic rst = 1'b0, rx_bit = 1'b0, rx_valid = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  sel8, sel1;
    logic        din8, din1, dv8, dv1, busy8, busy1, fd8, fd1, fe8, fe1;
    logic [31:0] cc8;
    logic [15:0] cc1;

    serial_demux_router #(.DATA_BITS(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid),
        .sel(sel8), .din(din8), .data_valid(dv8), .busy(busy8),
        .frame_done(fd8), .frame_err(fe8), .ch_count(cc8));

    serial_demux_router #(.DATA_BITS(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid),
        .sel(sel1), .din(din1), .data_valid(dv1), .busy(busy1),
        .frame_done(fd1), .frame_err(fe1), .ch_count(cc1));

    int tests = 0, fails = 0, done_pulses = 0;

    // Model: position within the frame (0 = waiting for start, 1-2 address,
    // 3..2+DB payload, 3+DB stop) plus the outputs each edge should produce.
    int db [2] = '{8, 1};
    int cm [2] = '{256, 16};
    int pos [2], addr [2], m_sel [2], m_din [2], m_dv [2], m_fd [2], m_fe [2];
    int cnt [2][4];

    task automatic model(input bit r, input bit b, input bit v);
        for (int i = 0; i < 2; i++) begin
            m_din[i] = 0; m_dv[i] = 0; m_fd[i] = 0; m_fe[i] = 0;
            if (r) begin
                pos[i] = 0; m_sel[i] = 0;
                for (int c = 0; c < 4; c++) cnt[i][c] = 0;
            end else if (v) begin
                if (pos[i] == 0) begin
                    if (b) pos[i] = 1;
                end else if (pos[i] == 1) begin
                    addr[i] = 2 * b; pos[i] = 2;
                end else if (pos[i] == 2) begin
                    m_sel[i] = addr[i] + b; pos[i] = 3;
                end else if (pos[i] < 3 + db[i]) begin
                    m_din[i] = b; m_dv[i] = 1; pos[i]++;
                end else begin
                    if (b) m_fe[i] = 1;
                    else begin
                        m_fd[i] = 1;
                        cnt[i][m_sel[i]] = (cnt[i][m_sel[i]] + 1) % cm[i];
                    end
                    pos[i] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("sel8",  {30'd0, sel8},  m_sel[0]);
        chk("din8",  {31'd0, din8},  m_din[0]);
        chk("dv8",   {31'd0, dv8},   m_dv[0]);
        chk("done8", {31'd0, fd8},   m_fd[0]);
        chk("err8",  {31'd0, fe8},   m_fe[0]);
        chk("busy8", {31'd0, busy8}, (pos[0] != 0) ? 1 : 0);
        chk("sel1",  {30'd0, sel1},  m_sel[1]);
        chk("din1",  {31'd0, din1},  m_din[1]);
        chk("dv1",   {31'd0, dv1},   m_dv[1]);
        chk("done1", {31'd0, fd1},   m_fd[1]);
        chk("err1",  {31'd0, fe1},   m_fe[1]);
        chk("busy1", {31'd0, busy1}, (pos[1] != 0) ? 1 : 0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("cnt8_ch%0d", c), {24'd0, cc8[c*8 +: 8]}, cnt[0][c]);
            chk($sformatf("cnt1_ch%0d", c), {28'd0, cc1[c*4 +: 4]}, cnt[1][c]);
        end
    endtask

    task automatic step(input bit r, input bit b, input bit v);
        @(negedge clk);
        rst = r; rx_bit = b; rx_valid = v;
        @(posedge clk);
        #1;
        model(r, b, v);
        if (fd8 === 1'b1) done_pulses++;
        check_all();
    endtask

    task automatic send_frame(input logic [1:0] a, input logic [7:0] data,
                              input bit stop, input int gap_after, input int gap_len);
        step(0, 1, 1);
        step(0, a[1], 1);
        step(0, a[0], 1);
        for (int k = 0; k < 8; k++) begin
            step(0, data[7-k], 1);
            if (k + 1 == gap_after)
                for (int g = 0; g < gap_len; g++) step(0, ($urandom % 2) != 0, 0);
        end
        step(0, stop, 1);
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b10110001;

        step(1, 0, 0);
        step(1, 1, 1);
        chk("rst_cnt8", cc8, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);

        // Good frame to channel 2, continuous valid.
        send_frame(2'b10, pat, 0, -1, 0);
        step(0, 0, 1);
        chk("t1_ch2", {24'd0, cc8[23:16]}, 32'd1);
        chk("t1_sel", {30'd0, sel8}, 32'd2);

        // Channel 1 with a 3-cycle stall after the 4th payload bit.
        send_frame(2'b01, pat, 0, 4, 3);
        chk("t2_ch1", {24'd0, cc8[15:8]}, 32'd1);

        // Bad stop bit to channel 3.
        send_frame(2'b11, pat, 1, -1, 0);
        chk("t3_err", {31'd0, fe8}, 32'd1);
        step(0, 0, 1);
        chk("t3_ch3", {24'd0, cc8[31:24]}, 32'd0);
        chk("t3_busy", {31'd0, busy8}, 32'd0);

        // Reset after the 5th payload bit, then a clean frame to channel 0.
        step(0, 1, 1); step(0, 0, 1); step(0, 0, 1);
        for (int k = 0; k < 5; k++) step(0, pat[7-k], 1);
        step(1, 1, 1);
        chk("t4_busy", {31'd0, busy8}, 32'd0);
        chk("t4_cnt", cc8, 32'd0);
        send_frame(2'b00, pat, 0, -1, 0);
        step(0, 0, 1);
        chk("t4_ch0", {24'd0, cc8[7:0]}, 32'd1);

        // Make channel 1 nonzero, then 256 back-to-back frames must wrap it back.
        send_frame(2'b01, pat, 0, -1, 0);
        done_pulses = 0;
        for (int f = 0; f < 256; f++) send_frame(2'b01, 8'($urandom), 0, -1, 0);
        chk("t5_pulses", done_pulses, 32'd256);
        chk("t5_wrap", {24'd0, cc8[15:8]}, 32'd1);

        // Idle line.
        for (int k = 0; k < 20; k++) step(0, 0, 1);
        chk("t6_sel", {30'd0, sel8}, 32'd1);

        // Random frames with random stalls and stop bits.
        for (int f = 0; f < 150; f++)
            send_frame(2'($urandom), 8'($urandom), ($urandom % 4) == 0,
                       $urandom_range(1, 8), $urandom_range(0, 3));

        // Raw random line noise, occasional reset.
        for (int k = 0; k < 3000; k++)
            step(($urandom % 700) == 0, ($urandom % 2) != 0, ($urandom % 4) != 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
